// File: rtl/mux_scan_ctrl_if.sv
// Bundle between the scan sequencer and its environment: scan control in,
// mux select out, captured word and status out.
interface mux_scan_ctrl_if;
  logic       start;
  logic       cont;
  logic       stop;
  logic       y_in;
  logic [1:0] sel;
  logic [3:0] word;
  logic       busy;
  logic       done;
  logic [7:0] scan_count;

  modport master (
    output start, cont, stop, y_in,
    input  sel, word, busy, done, scan_count
  );

  modport slave (
    input  start, cont, stop, y_in,
    output sel, word, busy, done, scan_count
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Steps a 4:1 mux select through all channels, waits SETTLE cycles per channel,
// samples the mux output and publishes the four bits as one word per scan.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input logic            clk,
  input logic            rst,
  mux_scan_ctrl_if.slave bus
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSettle = 2'd1;
  localparam logic [1:0] StSample = 2'd2;

  localparam logic [3:0] CntLast = 4'(SETTLE - 1);

  logic [1:0] state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic       cont_q, cont_d;
  logic [2:0] shadow_q, shadow_d;
  logic [3:0] word_q, word_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] count_q, count_d;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    cont_d   = cont_q;
    shadow_d = shadow_q;
    word_d   = word_q;
    count_d  = count_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        sel_d = 2'd0;
        if (bus.start && !bus.stop) begin
          state_d = StSettle;
          cnt_d   = 4'd0;
          cont_d  = bus.cont;
        end
      end
      StSettle: begin
        if (bus.stop) begin
          state_d  = StIdle;
          sel_d    = 2'd0;
          cont_d   = 1'b0;
          shadow_d = 3'd0;
        end else if (cnt_q == CntLast) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StSample: begin
        // An abort on the last channel must also suppress the word/count/done update.
        if (bus.stop) begin
          state_d  = StIdle;
          sel_d    = 2'd0;
          cont_d   = 1'b0;
          shadow_d = 3'd0;
        end else if (sel_q != 2'd3) begin
          shadow_d[sel_q] = bus.y_in;
          sel_d           = sel_q + 2'd1;
          cnt_d           = 4'd0;
          state_d         = StSettle;
        end else begin
          word_d  = {bus.y_in, shadow_q};
          count_d = count_q + 8'd1;
          done_d  = 1'b1;
          sel_d   = 2'd0;
          cnt_d   = 4'd0;
          state_d = cont_q ? StSettle : StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        sel_d   = 2'd0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      sel_q    <= 2'd0;
      cnt_q    <= 4'd0;
      cont_q   <= 1'b0;
      shadow_q <= 3'd0;
      word_q   <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      cont_q   <= cont_d;
      shadow_q <= shadow_d;
      word_q   <= word_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      count_q  <= count_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.word       = word_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.scan_count = count_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench: two sequencers (SETTLE=1 with a combinational mux, SETTLE=3
// with a mux output that lags sel by one cycle); expected scans queued, checked on done.
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_scan_ctrl_if b1 ();
  mux_scan_ctrl_if b3 ();

  mux_scan_ctrl #(.SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  mux_scan_ctrl #(.SETTLE(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  logic [3:0] mux1 = 4'd0;
  logic [3:0] mux3 = 4'd0;

  assign b1.y_in = mux1[b1.sel];
  always @(posedge clk) b3.y_in <= mux3[b3.sel];

  typedef struct {
    logic [3:0] w;
    logic [7:0] c;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push1(input logic [3:0] w, input logic [7:0] c);
    exp_t e;
    e.w = w;
    e.c = c;
    q1.push_back(e);
  endtask

  task automatic push3(input logic [3:0] w, input logic [7:0] c);
    exp_t e;
    e.w = w;
    e.c = c;
    q3.push_back(e);
  endtask

  // Monitors: every done pulse must match the oldest queued scan.
  always @(posedge clk) begin
    #1;
    if (b1.done === 1'b1) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL dut1 unexpected done: word=%h count=%0d, required no done",
                 b1.word, b1.scan_count);
      end else begin
        e1 = q1.pop_front();
        chk("dut1 word", 32'(b1.word), 32'(e1.w));
        chk("dut1 scan_count", 32'(b1.scan_count), 32'(e1.c));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (b3.done === 1'b1) begin
      if (q3.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL dut3 unexpected done: word=%h count=%0d, required no done",
                 b3.word, b3.scan_count);
      end else begin
        e3 = q3.pop_front();
        chk("dut3 word", 32'(b3.word), 32'(e3.w));
        chk("dut3 scan_count", 32'(b3.scan_count), 32'(e3.c));
      end
    end
  end

  initial begin
    b1.start = 1'b0; b1.cont = 1'b0; b1.stop = 1'b0;
    b3.start = 1'b0; b3.cont = 1'b0; b3.stop = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst sel", 32'(b1.sel), 0);
    chk("rst word", 32'(b1.word), 0);
    chk("rst busy", 32'(b1.busy), 0);
    chk("rst done", 32'(b1.done), 0);
    chk("rst scan_count", 32'(b1.scan_count), 0);
    chk("rst busy3", 32'(b3.busy), 0);

    // Single scan, 0110
    mux1 = 4'b0110;
    b1.start = 1'b1;
    b1.cont  = 1'b0;
    push1(4'b0110, 8'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) b1.start = 1'b0;
      chk("single sel seq", 32'(b1.sel), 32'(i / 2));
      chk("single busy", 32'(b1.busy), 1);
      chk("single done low", 32'(b1.done), 0);
    end
    @(negedge clk);
    chk("single E8 busy", 32'(b1.busy), 0);
    chk("single E8 done", 32'(b1.done), 1);
    chk("single E8 word", 32'(b1.word), 32'h6);
    chk("single E8 count", 32'(b1.scan_count), 1);
    chk("single E8 sel", 32'(b1.sel), 0);
    @(negedge clk);
    chk("single E9 done", 32'(b1.done), 0);

    // Continuous: 0110 then 1001 before scan 2's first sample
    b1.start = 1'b1;
    b1.cont  = 1'b1;
    push1(4'b0110, 8'd2);
    push1(4'b1001, 8'd3);
    for (int i = 0; i <= 17; i++) begin
      @(negedge clk);
      if (i == 0) begin
        b1.start = 1'b0;
        b1.cont  = 1'b0;
      end
      if (i == 8) mux1 = 4'b1001;
      chk("cont busy", 32'(b1.busy), 1);
      chk("cont done", 32'(b1.done), 32'((i == 8) || (i == 16)));
      if (i == 17) b1.stop = 1'b1;
    end
    @(negedge clk);
    b1.stop = 1'b0;
    chk("cont stop busy", 32'(b1.busy), 0);
    chk("cont stop word", 32'(b1.word), 32'h9);
    chk("cont stop count", 32'(b1.scan_count), 3);

    // Async reset mid-scan at E5
    mux1 = 4'b1111;
    b1.start = 1'b1;
    b1.cont  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) b1.start = 1'b0;
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst sel", 32'(b1.sel), 0);
    chk("arst word", 32'(b1.word), 0);
    chk("arst busy", 32'(b1.busy), 0);
    chk("arst done", 32'(b1.done), 0);
    chk("arst count", 32'(b1.scan_count), 0);
    @(negedge clk);
    rst = 1'b0;
    b1.cont = 1'b0;
    @(negedge clk);
    chk("post arst busy", 32'(b1.busy), 0);
    @(negedge clk);
    chk("post arst idle", 32'(b1.busy), 0);

    // Abort on final SAMPLE of scan 2
    mux1 = 4'b0110;
    b1.start = 1'b1;
    b1.cont  = 1'b1;
    push1(4'b0110, 8'd1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) b1.start = 1'b0;
      if (i == 8) mux1 = 4'b1111;
      if (i == 15) b1.stop = 1'b1;
    end
    @(negedge clk);
    b1.stop = 1'b0;
    b1.cont = 1'b0;
    chk("abort busy", 32'(b1.busy), 0);
    chk("abort sel", 32'(b1.sel), 0);
    chk("abort done", 32'(b1.done), 0);
    chk("abort word", 32'(b1.word), 32'h6);
    chk("abort count", 32'(b1.scan_count), 1);

    // start and stop together in IDLE
    b1.start = 1'b1;
    b1.stop  = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    b1.stop  = 1'b0;
    chk("start+stop busy", 32'(b1.busy), 0);
    @(negedge clk);
    chk("start+stop still idle", 32'(b1.busy), 0);
    chk("start+stop count", 32'(b1.scan_count), 1);

    // SETTLE=3, lagging mux output, 256 continuous scans to wrap
    mux3 = 4'b1010;
    @(negedge clk);
    b3.start = 1'b1;
    b3.cont  = 1'b1;
    push3(4'b1010, 8'd1);
    for (int k = 2; k <= 256; k++) push3(4'b0101, 8'(k));
    for (int i = 0; i <= 4096; i++) begin
      @(negedge clk);
      if (i == 0) begin
        b3.start = 1'b0;
        b3.cont  = 1'b0;
      end
      if (i < 16) chk("s3 sel seq", 32'(b3.sel), 32'(i / 4));
      if (i == 16) mux3 = 4'b0101;
      if (i == 30) b3.start = 1'b1;
      if (i == 31) b3.start = 1'b0;
      if (i == 40) chk("s3 busy mid", 32'(b3.busy), 1);
    end
    chk("wrap count", 32'(b3.scan_count), 0);
    chk("wrap done", 32'(b3.done), 1);
    chk("wrap busy", 32'(b3.busy), 1);
    chk("wrap word", 32'(b3.word), 32'h5);
    b3.stop = 1'b1;
    @(negedge clk);
    b3.stop = 1'b0;
    chk("s3 stop busy", 32'(b3.busy), 0);

    repeat (20) @(negedge clk);
    chk("q1 drained", 32'(q1.size()), 0);
    chk("q3 drained", 32'(q3.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
